// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
// cache_mem_arbiter
// Shares the single external memory port between the I-cache refill path
// and the D-cache refill/writeback path. A granted requester owns the port
// for one whole-line burst. That burst is a command, then BURST_LEN read or write beats,
// then a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_req/i_addr                 I-cache line read request
//   i_gnt/i_rvalid/i_rdata/i_done  I-cache grant, read beats, completion
//   d_req/d_we/d_addr/d_wdata    D-cache request (we=1 writeback)
//   d_gnt/d_wready/d_rvalid/d_rdata/d_done  D-cache grant, beats, completion
//   mem_req/mem_we/mem_addr/mem_wdata  memory command and write data
//   mem_ready/mem_rvalid/mem_rdata     memory handshake and read data
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking. Without it,
// the D-cache always wins a simultaneous request.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_wready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q, last_d;
  owner_t           winner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_beat;
  logic             own_d;

  assign own_d     = (owner_q == OWN_D);
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

  // A lone requester always wins; only a tie depends on the build option.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      winner = (last_q == OWN_D) ? OWN_I : OWN_D;
    end else begin
      winner = d_req ? OWN_D : OWN_I;
    end
`else
    winner = d_req ? OWN_D : OWN_I;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registered state so reset forces them low at once.
  // Read data is passed through only while the owner is in READ.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    i_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_done    = 1'b0;
    d_gnt     = 1'b0;
    d_wready  = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_done    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (state_q != S_IDLE) begin
      i_gnt = !own_d;
      d_gnt = own_d;
    end

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = winner;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        mem_req  = 1'b1;
        mem_addr = own_d ? d_addr : i_addr;
        mem_we   = own_d && d_we;
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = (own_d && d_we) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (own_d) begin
          d_rvalid = mem_rvalid;
          d_rdata  = mem_rdata;
        end else begin
          i_rvalid = mem_rvalid;
          i_rdata  = mem_rdata;
        end
        if (mem_rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        mem_wdata = d_wdata;
        d_wready  = mem_ready;
        if (mem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        i_done  = !own_d;
        d_done  = own_d;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
